i2c_slave_regbank: RTL and testbench
====================================

Name: i2c_slave_regbank

Overview:
- Register-bank back end sitting directly downstream of the I2C slave core. It consumes the slave's received-byte stream and bus flags, and supplies transmit bytes over the write_data/write_en/write_rdy handshake.
- Write transaction: the first data byte sets the register pointer; subsequent bytes write registers with auto-increment.
- Read transaction: registers are streamed from the pointer onward. A host-side port gives the application register access and write notification.

Parameters:
- NREG, 16, number of 8-bit registers (power of 2, 2..256).
- AW, 4, pointer width = log2(NREG).
- RST_VAL, 8'h00, reset value of every register.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rx_data  in  8  byte received from the I2C slave core (its read_data).
- rx_en  in  1  1-cycle pulse; rx_data valid (core read_en).
- tx_data  out  8  byte to transmit (to core write_data).
- tx_en  out  1  1-cycle pulse loading tx_data into the core (core write_en).
- tx_rdy  in  1  core can accept a transmit byte (core write_rdy).
- hitar  in  1  level; slave address matched for the current transaction.
- flag_start / flag_restart / flag_stop / flag_err  in  1 each  1-cycle event pulses from the core.
- host_addr  in  AW  host register address.
- host_rdata  out  8  mem[host_addr], combinational read.
- host_we  in  1  host write strobe.
- host_wdata  in  8  host write data.
- upd_valid  out  1  1-cycle pulse; I2C wrote a register.
- upd_addr  out  AW  address written (valid with upd_valid).
- ptr  out  AW  current register pointer.
- err_cnt  out  8  saturating protocol-error counter.

Behaviour:
- Reset (rst high at a clk edge): all registers = RST_VAL; ptr=0; state=IDLE; tx_en=0; tx_data=0; upd_valid=0; err_cnt=0. Reset mid-transaction aborts it with no further tx_en.
- FSM states: IDLE, PTR, WDATA, RDATA.
  - IDLE -> PTR on flag_start && hitar.
  - PTR: rx_en -> ptr = rx_data[AW-1:0] (upper bits ignored), go to WDATA.
  - WDATA: rx_en -> mem[ptr] = rx_data; upd_valid/upd_addr=ptr the next cycle; ptr = ptr+1.
  - PTR or WDATA -> RDATA on flag_restart && hitar; ptr is kept.
  - Any state -> IDLE on flag_stop, or on flag_restart/flag_start with hitar low.
  - flag_err -> IDLE from any state; err_cnt+1, saturating at 255.
- Transmit (RDATA only):
  - When tx_rdy=1 and tx_pend=0: drive tx_data = mem[ptr] and tx_en=1 for one cycle, then ptr = ptr+1 and tx_pend=1.
  - tx_pend clears when tx_rdy is sampled low. This gives exactly one tx_en per tx_rdy high period.
  - Latency: tx_en asserts the cycle after tx_rdy is first seen high.
- Pointer: wraps NREG-1 -> 0 for both writes and reads.
- Event priority in one cycle: flag_err > flag_stop > flag_restart > flag_start > rx_en. A lower-priority event coinciding with a higher one is ignored.
- rx_en in IDLE or RDATA: byte dropped, no state change.
- Host port:
  - host_we writes mem[host_addr] at the clk edge.
  - If host_we and an I2C write hit the same address in the same cycle, the host wins; upd_valid still pulses.
  - host_rdata reflects writes from the following cycle.

Optional Feature:
- Macro I2C_REGBANK_RO_MASK_EN. When defined, an extra parameter RO_MASK [NREG-1:0] (default all 0) is active.
  - I2C writes to a register whose mask bit is 1 are discarded: no upd_valid, ptr still increments, err_cnt+1.
  - Host writes are unaffected.
- Without the macro: all registers are I2C-writable and no RO_MASK parameter exists.

Decomposition:
- Package i2c_regbank_pkg:
  - state enum (IDLE, PTR, WDATA, RDATA);
  - ERR_CNT_W=8;
  - a default register-width constant of 8.
- One sub-module, i2c_regbank_mem: NREG x 8 storage, one sync write port (host-priority mux), one combinational read port for I2C and one for host.

Test Plan:
- Start+hitar, rx 8'h03, 8'hAA, 8'h55, stop -> mem[3]=AA, mem[4]=55; upd_valid pulses with upd_addr 3 then 4; ptr=5; state IDLE.
- Write ptr 8'h0F, then restart+hitar, tx_rdy pulsed high 3 times -> tx_data F, 0, 1 contents (wrap); exactly 3 tx_en pulses.
- tx_rdy held high 10 cycles in RDATA -> exactly one tx_en.
- Host writes mem[4]=77 while I2C writes mem[4]=11 in the same cycle -> mem[4]=77; upd_valid=1, upd_addr=4.
- flag_err mid-WDATA, then rx_en 8'hEE -> byte ignored; state IDLE; err_cnt=1. 300 errors -> err_cnt=255.
- rst asserted during RDATA with tx_rdy high -> no tx_en after reset; ptr=0; all registers = 00.

Source files
------------

// File: rtl/i2c_regbank_pkg.sv
// i2c_regbank_pkg: shared types and widths for the I2C slave register bank
package i2c_regbank_pkg;
  typedef enum logic [1:0] {IDLE, PTR, WDATA, RDATA} state_e;
  localparam int ERR_CNT_W = 8;
  localparam int REG_W = 8;
endpackage

// File: rtl/i2c_regbank_mem.sv
// i2c_regbank_mem: NREG x REG_W storage, one write port (host beats I2C on a clash), two async read ports
module i2c_regbank_mem
  import i2c_regbank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW = 4,
  parameter logic [REG_W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic i2c_we,
  input  logic [AW-1:0] i2c_addr,
  input  logic [REG_W-1:0] i2c_wdata,
  input  logic [AW-1:0] i2c_raddr,
  output logic [REG_W-1:0] i2c_rdata,
  input  logic host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [REG_W-1:0] host_wdata,
  output logic [REG_W-1:0] host_rdata
);
  logic [REG_W-1:0] mem_q [NREG];
  logic [REG_W-1:0] mem_d [NREG];
  always_comb begin
    for (int i = 0; i < NREG; i++)
      mem_d[i] = (host_we && host_addr == AW'(i)) ? host_wdata :
                 (i2c_we && i2c_addr == AW'(i)) ? i2c_wdata : mem_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREG; i++) mem_q[i] <= RST_VAL;
    else mem_q <= mem_d;
  end
  assign i2c_rdata = mem_q[i2c_raddr];
  assign host_rdata = mem_q[host_addr];
endmodule

// File: rtl/i2c_slave_regbank.sv
// i2c_slave_regbank: pointer/auto-increment register bank behind an I2C slave core.
// Optional I2C_REGBANK_RO_MASK_EN adds RO_MASK: masked registers reject I2C writes and bump err_cnt.
module i2c_slave_regbank
  import i2c_regbank_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW = 4,
  parameter logic [REG_W-1:0] RST_VAL = 8'h00
`ifdef I2C_REGBANK_RO_MASK_EN
  , parameter logic [NREG-1:0] RO_MASK = '0
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] rx_data,
  input  logic rx_en,
  output logic [7:0] tx_data,
  output logic tx_en,
  input  logic tx_rdy,
  input  logic hitar,
  input  logic flag_start,
  input  logic flag_restart,
  input  logic flag_stop,
  input  logic flag_err,
  input  logic [AW-1:0] host_addr,
  output logic [7:0] host_rdata,
  input  logic host_we,
  input  logic [7:0] host_wdata,
  output logic upd_valid,
  output logic [AW-1:0] upd_addr,
  output logic [AW-1:0] ptr,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  state_e state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d, upd_addr_q, upd_addr_d;
  logic [7:0] tx_data_q, tx_data_d, i2c_rdata;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic tx_en_q, tx_en_d, tx_pend_q, tx_pend_d, upd_valid_q, upd_valid_d;
  logic any_flag, rx_ptr, rx_wr, ro, i2c_we, tx_fire, err_inc;
  logic unused_rx_hi;
  assign unused_rx_hi = ^rx_data;
`ifdef I2C_REGBANK_RO_MASK_EN
  assign ro = RO_MASK[ptr_q];
`else
  assign ro = 1'b0;
`endif
  always_comb begin
    any_flag = flag_err | flag_stop | flag_restart | flag_start;
    rx_ptr = rx_en && !any_flag && state_q == PTR;
    rx_wr = rx_en && !any_flag && state_q == WDATA;
    i2c_we = rx_wr && !ro;
    tx_fire = state_q == RDATA && tx_rdy && !tx_pend_q && !any_flag;
    // a restart with our address outside a write phase is treated as a fresh start
    state_d = flag_err ? IDLE :
              flag_stop ? IDLE :
              flag_restart ? (!hitar ? IDLE : (state_q == PTR || state_q == WDATA) ? RDATA : PTR) :
              flag_start ? (hitar ? PTR : IDLE) :
              rx_ptr ? WDATA : state_q;
    ptr_d = rx_ptr ? rx_data[AW-1:0] : (rx_wr || tx_fire) ? ptr_q + AW'(1) : ptr_q;
    err_inc = flag_err || (rx_wr && ro);
    err_cnt_d = (err_inc && err_cnt_q != '1) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;
    tx_pend_d = tx_rdy && (tx_pend_q || tx_fire);
    tx_en_d = tx_fire;
    tx_data_d = tx_fire ? i2c_rdata : tx_data_q;
    upd_valid_d = i2c_we;
    upd_addr_d = i2c_we ? ptr_q : upd_addr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      err_cnt_q <= '0;
      tx_pend_q <= 1'b0;
      tx_en_q <= 1'b0;
      tx_data_q <= '0;
      upd_valid_q <= 1'b0;
      upd_addr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      err_cnt_q <= err_cnt_d;
      tx_pend_q <= tx_pend_d;
      tx_en_q <= tx_en_d;
      tx_data_q <= tx_data_d;
      upd_valid_q <= upd_valid_d;
      upd_addr_q <= upd_addr_d;
    end
  end
  i2c_regbank_mem #(.NREG(NREG), .AW(AW), .RST_VAL(RST_VAL)) u_mem (
    .clk(clk), .rst(rst),
    .i2c_we(i2c_we), .i2c_addr(ptr_q), .i2c_wdata(rx_data),
    .i2c_raddr(ptr_q), .i2c_rdata(i2c_rdata),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );
  assign tx_data = tx_data_q;
  assign tx_en = tx_en_q;
  assign upd_valid = upd_valid_q;
  assign upd_addr = upd_addr_q;
  assign ptr = ptr_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_i2c_slave_regbank.sv
// tb_i2c_slave_regbank: directed vectors for the I2C register bank
module tb_i2c_slave_regbank;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data, host_rdata, host_wdata = 0, err_cnt;
  logic rx_en = 0, tx_en, tx_rdy = 0, hitar = 0;
  logic flag_start = 0, flag_restart = 0, flag_stop = 0, flag_err = 0;
  logic [3:0] host_addr = 0, upd_addr, ptr;
  logic host_we = 0, upd_valid;
  int n_chk = 0, n_pass = 0;
  localparam logic [4:0] E_ERR = 5'b10000, E_STOP = 5'b01000, E_RST = 5'b00100,
                         E_START = 5'b00010, E_RX = 5'b00001;

  i2c_slave_regbank dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_en(rx_en), .tx_data(tx_data),
    .tx_en(tx_en), .tx_rdy(tx_rdy), .hitar(hitar), .flag_start(flag_start),
    .flag_restart(flag_restart), .flag_stop(flag_stop), .flag_err(flag_err),
    .host_addr(host_addr), .host_rdata(host_rdata), .host_we(host_we),
    .host_wdata(host_wdata), .upd_valid(upd_valid), .upd_addr(upd_addr),
    .ptr(ptr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [4:0] f, input logic [7:0] d);
    {flag_err, flag_stop, flag_restart, flag_start, rx_en} = f;
    rx_data = d;
    step();
    {flag_err, flag_stop, flag_restart, flag_start, rx_en} = '0;
  endtask

  task automatic hwr(input logic [3:0] a, input logic [7:0] d);
    host_we = 1; host_addr = a; host_wdata = d;
    step();
    host_we = 0;
  endtask

  task automatic txp(input int hi, output int n, output logic [7:0] last);
    n = 0; last = 0;
    tx_rdy = 1;
    for (int i = 0; i < hi; i++) begin
      step();
      if (tx_en) begin n++; last = tx_data; end
    end
    tx_rdy = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (tx_en) begin n++; last = tx_data; end
    end
  endtask

  initial begin
    int n;
    logic [7:0] d;
    logic [7:0] exp_tx [3];
    exp_tx = '{8'hC1, 8'hC2, 8'hC3};
    step(); step();
    rst = 0;
    host_addr = 3;
    chk("rst_ptr", ptr, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_upd", upd_valid, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_mem", host_rdata, 0);
    hitar = 1;
    // write transaction: pointer 3, then AA, 55
    ev(E_START, 0);
    ev(E_RX, 8'h03);
    chk("ptr_set", ptr, 3);
    chk("ptr_no_upd", upd_valid, 0);
    ev(E_RX, 8'hAA);
    chk("wr1_upd", upd_valid, 1);
    chk("wr1_addr", upd_addr, 3);
    ev(E_RX, 8'h55);
    chk("wr2_upd", upd_valid, 1);
    chk("wr2_addr", upd_addr, 4);
    chk("wr2_ptr", ptr, 5);
    ev(E_STOP, 0);
    chk("upd_once", upd_valid, 0);
    ev(E_RX, 8'h99);
    chk("idle_drop_upd", upd_valid, 0);
    chk("idle_drop_ptr", ptr, 5);
    host_addr = 3; #1 chk("mem3", host_rdata, 8'hAA);
    host_addr = 4; #1 chk("mem4", host_rdata, 8'h55);
    // read with wrap from 15
    hwr(15, 8'hC1); hwr(0, 8'hC2); hwr(1, 8'hC3); hwr(5, 8'h5A);
    ev(E_START, 0);
    ev(E_RX, 8'h0F);
    ev(E_RST, 0);
    chk("rd_ptr_kept", ptr, 15);
    for (int k = 0; k < 3; k++) begin
      txp(2, n, d);
      chk($sformatf("rd%0d_cnt", k), n, 1);
      chk($sformatf("rd%0d_data", k), d, exp_tx[k]);
    end
    chk("rd_ptr_wrap", ptr, 2);
    ev(E_STOP, 0);
    // tx_rdy held high: a single byte
    ev(E_START, 0);
    ev(E_RX, 8'h05);
    ev(E_RST, 0);
    txp(10, n, d);
    chk("hold_cnt", n, 1);
    chk("hold_data", d, 8'h5A);
    chk("hold_ptr", ptr, 6);
    ev(E_STOP, 0);
    // host and I2C write the same register in one cycle
    ev(E_START, 0);
    ev(E_RX, 8'h04);
    host_we = 1; host_addr = 4; host_wdata = 8'h77;
    ev(E_RX, 8'h11);
    host_we = 0;
    chk("clash_upd", upd_valid, 1);
    chk("clash_addr", upd_addr, 4);
    chk("clash_mem", host_rdata, 8'h77);
    ev(E_STOP, 0);
    // error mid-write
    ev(E_START, 0);
    ev(E_RX, 8'h08);
    ev(E_RX, 8'h12);
    ev(E_ERR | E_RX, 8'h34);
    chk("err_cnt1", err_cnt, 1);
    chk("err_upd", upd_valid, 0);
    ev(E_RX, 8'hEE);
    chk("err_drop_upd", upd_valid, 0);
    chk("err_drop_ptr", ptr, 9);
    host_addr = 8; #1 chk("mem8", host_rdata, 8'h12);
    host_addr = 9; #1 chk("mem9", host_rdata, 8'h00);
    for (int i = 0; i < 299; i++) ev(E_ERR, 0);
    chk("err_sat", err_cnt, 255);
    // reset during a read
    ev(E_START, 0);
    ev(E_RX, 8'h02);
    ev(E_RST, 0);
    tx_rdy = 1; rst = 1;
    step();
    rst = 0;
    chk("rst_rd_tx_en", tx_en, 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tx_en) n++;
    end
    tx_rdy = 0;
    chk("rst_rd_no_tx", n, 0);
    chk("rst_rd_ptr", ptr, 0);
    chk("rst_rd_err", err_cnt, 0);
    for (int a = 0; a < 16; a++) begin
      host_addr = 4'(a);
      #1 chk($sformatf("rst_mem%0d", a), host_rdata, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
